// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word/register widths, stack-pointer index and
// the memory-stage FSM state type.
package cpu_pkg;
  localparam int WORD_W     = 16;
  localparam int REG_ADDR_W = 4;

  localparam logic [REG_ADDR_W-1:0] SP_REG = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB output register: single-cycle writeback slot plus the one-cycle
// ret_wb pulse carrying the return address read from the stack.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] reg_rd,
  input  logic [WORD_W-1:0]     data,
  input  logic                  ret_pulse,
  input  logic [WORD_W-1:0]     ret_pc,
  output logic                  wb_valid,
  output logic                  RegWrite_out,
  output logic [REG_ADDR_W-1:0] reg_rd_out,
  output logic [WORD_W-1:0]     wb_data,
  output logic                  ret_wb,
  output logic [WORD_W-1:0]     PC_stack_pointer
);

  // Valid/enable bits drop every cycle that has no load; payload holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid         <= 1'b0;
      RegWrite_out     <= 1'b0;
      reg_rd_out       <= '0;
      wb_data          <= '0;
      ret_wb           <= 1'b0;
      PC_stack_pointer <= '0;
    end else begin
      wb_valid     <= load;
      RegWrite_out <= load & reg_write;
      ret_wb       <= ret_pulse;
      if (load) begin
        reg_rd_out <= reg_rd;
        wb_data    <= data;
      end
      if (ret_pulse) begin
        PC_stack_pointer <= ret_pc;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: req/ack data-memory handshake, pipe stall and MEM/WB
// register. Optional access timeout is built when MEM_TIMEOUT_EN is defined.
module mem_stage
  import cpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  flush,
  input  logic                  RegWrite_in,
  input  logic                  MemWrite_in,
  input  logic                  MemRead_in,
  input  logic                  mem_to_reg_in,
  input  logic                  ret_future_in,
  input  logic [REG_ADDR_W-1:0] reg_rd_in,
  input  logic [WORD_W-1:0]     alu_result,
  input  logic [WORD_W-1:0]     sw_data,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [WORD_W-1:0]     dmem_addr,
  output logic [WORD_W-1:0]     dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [WORD_W-1:0]     dmem_rdata,
  output logic                  stall,
  output logic                  wb_valid,
  output logic                  RegWrite_out,
  output logic [REG_ADDR_W-1:0] reg_rd_out,
  output logic [WORD_W-1:0]     wb_data,
  output logic                  ret_wb,
  output logic [WORD_W-1:0]     PC_stack_pointer,
  output logic                  mem_err
);

  mem_state_t state_reg;
  logic       memop;
  logic       complete;
  logic       pass_through;
  logic       timeout_hit;
  logic       load_wb;

  assign memop = in_valid & ~flush & (MemRead_in | MemWrite_in);

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic       mem_err_reg;

  // A same-cycle ack takes priority over the timeout.
  assign timeout_hit = (state_reg == WAIT) && (wait_cnt_reg == 8'(TIMEOUT_CYCLES)) && !dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_reg <= '0;
      mem_err_reg  <= 1'b0;
    end else begin
      wait_cnt_reg <= (state_reg == WAIT) ? wait_cnt_reg + 8'd1 : 8'd0;
      if (timeout_hit) begin
        mem_err_reg <= 1'b1;
      end
    end
  end

  assign mem_err = mem_err_reg;
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // Reset gates the request so an in-flight access is dropped at once.
  assign dmem_req   = !rst && (((state_reg == IDLE) && memop) || ((state_reg == WAIT) && !timeout_hit));
  assign dmem_we    = dmem_req & MemWrite_in;
  assign dmem_addr  = alu_result;
  assign dmem_wdata = sw_data;
  assign stall      = dmem_req & ~dmem_ack;

  assign complete     = dmem_req & dmem_ack;
  assign pass_through = !rst && (state_reg == IDLE) && in_valid && !flush && !(MemRead_in | MemWrite_in);
  assign load_wb      = complete | pass_through | timeout_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (memop && !dmem_ack) state_reg <= WAIT;
        WAIT:    if (complete || timeout_hit) state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  mem_wb_reg u_wb_reg (
    .clk              (clk),
    .rst              (rst),
    .load             (load_wb),
    .reg_write        (RegWrite_in & ~timeout_hit),
    .reg_rd           (reg_rd_in),
    .data             (mem_to_reg_in ? dmem_rdata : alu_result),
    .ret_pulse        (complete & ret_future_in & ~MemWrite_in),
    .ret_pc           (dmem_rdata),
    .wb_valid         (wb_valid),
    .RegWrite_out     (RegWrite_out),
    .reg_rd_out       (reg_rd_out),
    .wb_data          (wb_data),
    .ret_wb           (ret_wb),
    .PC_stack_pointer (PC_stack_pointer)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized
// instruction stream against a transaction-level memory/writeback model.
module tb_mem_stage;
  import cpu_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_valid = 1'b0;
  logic                  flush = 1'b0;
  logic                  RegWrite_in = 1'b0;
  logic                  MemWrite_in = 1'b0;
  logic                  MemRead_in = 1'b0;
  logic                  mem_to_reg_in = 1'b0;
  logic                  ret_future_in = 1'b0;
  logic [REG_ADDR_W-1:0] reg_rd_in = '0;
  logic [WORD_W-1:0]     alu_result = '0;
  logic [WORD_W-1:0]     sw_data = '0;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [WORD_W-1:0]     dmem_addr;
  logic [WORD_W-1:0]     dmem_wdata;
  logic                  dmem_ack = 1'b0;
  logic [WORD_W-1:0]     dmem_rdata = '0;
  logic                  stall;
  logic                  wb_valid;
  logic                  RegWrite_out;
  logic [REG_ADDR_W-1:0] reg_rd_out;
  logic [WORD_W-1:0]     wb_data;
  logic                  ret_wb;
  logic [WORD_W-1:0]     PC_stack_pointer;
  logic                  mem_err;

  int checks = 0;
  int errors = 0;
  logic [WORD_W-1:0] mem_model [logic [WORD_W-1:0]];

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
    .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
    .mem_to_reg_in(mem_to_reg_in), .ret_future_in(ret_future_in),
    .reg_rd_in(reg_rd_in), .alu_result(alu_result), .sw_data(sw_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .stall(stall),
    .wb_valid(wb_valid), .RegWrite_out(RegWrite_out), .reg_rd_out(reg_rd_out),
    .wb_data(wb_data), .ret_wb(ret_wb), .PC_stack_pointer(PC_stack_pointer), .mem_err(mem_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One instruction from presentation to the cycle after its writeback slot.
  // Called and returns just after a falling edge. lat = cycles until ack.
  task automatic do_instr(input int id, input bit rw, input bit mw, input bit mr,
                          input bit m2r, input bit retf, input bit fl,
                          input logic [3:0] rd, input logic [15:0] alu,
                          input logic [15:0] swd, input int lat_in);
    bit          is_mem  = !fl && (mw || mr);
    bit          is_read = is_mem && !mw;
    int          lat     = is_mem ? lat_in : 0;
    int          stalls  = 0;
    logic [15:0] rdata_v;
    logic [15:0] exp_data;
    if (is_read && mem_model.exists(alu)) rdata_v = mem_model[alu];
    else rdata_v = 16'($urandom);
    in_valid = 1'b1; flush = fl; RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr;
    mem_to_reg_in = m2r; ret_future_in = retf; reg_rd_in = rd; alu_result = alu; sw_data = swd;
    for (int c = 0; c <= lat; c++) begin
      dmem_ack   = is_mem && (c == lat);
      dmem_rdata = (c == lat) ? rdata_v : 16'($urandom);
      #1;
      check("req", dmem_req, is_mem);
      if (stall) stalls++;
      if (dmem_ack) begin
        check("addr", dmem_addr, alu);
        check("we", dmem_we, mw);
        if (mw) check("wdata", dmem_wdata, swd);
      end
      @(negedge clk);
    end
    if (is_mem && mw) mem_model[alu] = swd;
    dmem_ack = 1'b0; in_valid = 1'b0; flush = 1'b0;
    exp_data = m2r ? rdata_v : alu;
    #1;
    check("stall_cycles", stalls, lat);
    check("wb_valid", wb_valid, !fl);
    if (!fl) begin
      check("regwrite", RegWrite_out, rw);
      check("reg_rd", reg_rd_out, rd);
      check("wb_data", wb_data, exp_data);
    end
    check("ret_wb", ret_wb, retf && is_read);
    if (retf && is_read) check("pc_sp", PC_stack_pointer, rdata_v);
    @(negedge clk);
    #1;
    check("slot_clear_valid", wb_valid, 1'b0);
    check("slot_clear_ret", ret_wb, 1'b0);
    check("slot_clear_rw", RegWrite_out, 1'b0);
    $display("txn %0d rw=%0b mw=%0b mr=%0b m2r=%0b ret=%0b fl=%0b rd=%0d addr=%h wd=%h lat=%0d data=%h stalls=%0d",
             id, rw, mw, mr, m2r, retf, fl, rd, alu, swd, lat, exp_data, stalls);
  endtask

  initial begin
    int tmo_stalls;
    @(negedge clk);
    #1;
    check("rst_req", dmem_req, 1'b0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_wb_data", wb_data, 16'h0);
    check("rst_mem_err", mem_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // zero-wait load, 3-wait store, return, ALU pass-through, flush
    do_instr(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 16'h0040, 16'h0000, 0);
    do_instr(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 16'h0010, 16'h1234, 3);
    mem_model[16'h0020] = 16'h0100;
    do_instr(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, SP_REG, 16'h0020, 16'h0000, 2);
    do_instr(3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 16'h00FF, 16'h0000, 0);
    do_instr(4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0030, 16'hCAFE, 1);
    do_instr(5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd2, 16'h0030, 16'h0000, 0);
    do_instr(6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 16'h0030, 16'h0000, 0);

    // stray ack with no request
    dmem_ack = 1'b1;
    #1;
    check("stray_ack_req", dmem_req, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("stray_ack_wb", wb_valid, 1'b0);

    for (int i = 0; i < 50; i++) begin
      do_instr(100 + i, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), ($urandom_range(0, 7) == 0),
               4'($urandom), {12'h0, 1'b1, 3'($urandom)}, 16'($urandom),
               $urandom_range(0, 3));
    end

    // reset during the second cycle of a pending load
    in_valid = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1;
    mem_to_reg_in = 1'b1; ret_future_in = 1'b1; alu_result = 16'h0050; reg_rd_in = 4'd9;
    dmem_ack = 1'b0;
    @(negedge clk);
    #1;
    check("pre_rst_req", dmem_req, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_req", dmem_req, 1'b0);
    check("midrst_stall", stall, 1'b0);
    check("midrst_wb_valid", wb_valid, 1'b0);
    check("midrst_wb_data", wb_data, 16'h0);
    check("midrst_reg_rd", reg_rd_out, 4'd0);
    check("midrst_pc", PC_stack_pointer, 16'h0);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_idle", dmem_req, 1'b0);
    @(negedge clk);
    #1;
    check("post_rst_wb", wb_valid, 1'b0);
    $display("txn reset-mid-wait done");

`ifdef MEM_TIMEOUT_EN
    // timeout with TIMEOUT_CYCLES=4: issue cycle plus four WAIT cycles stalled
    in_valid = 1'b1; MemRead_in = 1'b1; MemWrite_in = 1'b0; RegWrite_in = 1'b1;
    ret_future_in = 1'b1; alu_result = 16'h0060; dmem_ack = 1'b0;
    tmo_stalls = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (!stall) break;
      tmo_stalls++;
      @(negedge clk);
    end
    check("tmo_stall_cycles", tmo_stalls, 5);
    check("tmo_req_drop", dmem_req, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("tmo_wb_valid", wb_valid, 1'b1);
    check("tmo_regwrite", RegWrite_out, 1'b0);
    check("tmo_ret", ret_wb, 1'b0);
    check("tmo_mem_err", mem_err, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("tmo_mem_err_sticky", mem_err, 1'b1);
    check("tmo_idle", dmem_req, 1'b0);
    $display("txn timeout stalls=%0d", tmo_stalls);
`else
    tmo_stalls = 0;
    check("no_timeout_mem_err", mem_err, 1'b0 + 1'(tmo_stalls));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage between the execute stage and register writeback. Takes the execute stage's results (ALU address, store data, destination register, control bits), runs one load or store per instruction over a req/ack data-memory handshake, and stalls the pipe while the memory is busy. It registers the MEM/WB outputs and produces the `ret_wb` / `PC_stack_pointer` pair that the execute stage's PC update logic uses to complete a return.

## Interface
- `TIMEOUT_CYCLES`, default 15: maximum WAIT cycles before an access is abandoned. Used only with `MEM_TIMEOUT_EN`. Range 1..255.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: EX/MEM slot holds a live instruction.
- `flush` in 1: kill the instruction presented this cycle (honoured in IDLE only).
- `RegWrite_in`, `MemWrite_in`, `MemRead_in`, `mem_to_reg_in`, `ret_future_in` in 1 each: control bits from execute.
- `reg_rd_in` in 4: destination register.
- `alu_result` in 16: memory address or ALU value.
- `sw_data` in 16: store data (PC on call).
- `dmem_req` out 1: access request.
- `dmem_we` out 1: 1 = write.
- `dmem_addr` out 16: word address.
- `dmem_wdata` out 16: write data.
- `dmem_ack` in 1: access complete; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 16: read data.
- `stall` out 1: hold the upstream pipe.
- `wb_valid`, `RegWrite_out` out 1 each: writeback slot valid / register write enable.
- `reg_rd_out` out 4: writeback destination.
- `wb_data` out 16: writeback value.
- `ret_wb` out 1: return address is ready.
- `PC_stack_pointer` out 16: return address read from the stack.
- `mem_err` out 1: sticky timeout flag.

## Operation
- Memory op (memop) = `in_valid & !flush & (MemRead_in | MemWrite_in)`. If both read and write are set, the access is a write and the read is ignored.
- FSM states: IDLE, WAIT.
- **IDLE**
  - memop: assert `dmem_req` combinationally from the inputs.
  - memop with `dmem_ack` in the same cycle: complete and stay in IDLE.
  - memop without `dmem_ack`: go to WAIT.
  - Non-memop valid instruction: pass through to the WB register in one cycle.
- **WAIT**
  - `dmem_req` held at 1.
  - Address, write data and write enable are taken from the upstream inputs. Upstream must hold them stable while `stall`=1.
  - `dmem_ack` completes the access and returns the FSM to IDLE.
- `stall` = `dmem_req & !dmem_ack`.
- Completion loads the WB register on the clock edge:
  - `wb_valid`=1.
  - `RegWrite_out` = `RegWrite_in`.
  - `reg_rd_out` = `reg_rd_in`.
  - `wb_data` = `mem_to_reg_in ? dmem_rdata : alu_result`.
- Return: `ret_future_in` on a completed read pulses `ret_wb` for one cycle with `PC_stack_pointer` = `dmem_rdata`.
- The WB register is a single-cycle slot. `wb_valid`, `RegWrite_out` and `ret_wb` are 0 in any cycle that follows no completion.
- `flush` in WAIT is ignored: an access already issued always completes.

## Timing
- All outputs reset to 0; FSM resets to IDLE. Reset asserted mid-access drops `dmem_req` immediately (async) and discards the access.
- Zero-wait memory (ack with req): 1-cycle latency, no stall.
- N-cycle memory: `stall` high for N cycles; WB outputs update on the edge after `dmem_ack`.
- Back-to-back memops: the next request may issue in the cycle after completion. There is no bubble when upstream presents the next instruction.
- `dmem_ack` seen while `dmem_req`=0 is ignored.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - An 8-bit counter clears on entering WAIT and increments on each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` with no ack, the access is abandoned: `dmem_req` drops, `stall` releases, and the WB slot loads `wb_valid`=1, `RegWrite_out`=0, `ret_wb`=0.
  - `mem_err` sets and stays set until `rst`.
  - An ack arriving in the same cycle as the timeout wins.
- `MEM_TIMEOUT_EN` undefined: WAIT holds indefinitely; `mem_err` is tied to 0; no counter logic is built.

## Structure
- Shared package `cpu_pkg` holds:
  - the `mem_state_t` enum {IDLE, WAIT};
  - `WORD_W`=16 and `REG_ADDR_W`=4;
  - the stack-pointer register index constant `SP_REG`=4'hF.
- One sub-module, `mem_wb_reg`: the WB output register with async reset, plus the `ret_wb` pulse logic. The FSM, handshake and timeout logic stay in `mem_stage`.

## Test plan
- **Zero-wait load:** `alu_result`=16'h0040, MemRead, mem_to_reg, `reg_rd_in`=3; ack in the same cycle with rdata=16'hBEEF. Expect `stall` never asserted and, next cycle, `wb_valid`=1, `reg_rd_out`=3, `wb_data`=16'hBEEF.
- **3-wait store:** addr 16'h0010, `sw_data`=16'h1234, ack after 3 cycles. Expect `dmem_we`=1, `stall` high for exactly 3 cycles, `RegWrite_out`=0 on completion.
- **Return:** `ret_future_in`=1, read with ack returning 16'h0100. Expect `ret_wb` pulsed for exactly one cycle with `PC_stack_pointer`=16'h0100.
- **ALU pass-through:** non-memory op with `alu_result`=16'h00FF, `RegWrite_in`=1. Expect `dmem_req`=0 and `wb_data`=16'h00FF one cycle later.
- **Reset mid-WAIT:** assert `rst` during cycle 2 of a pending load. Expect `dmem_req`=0 immediately, all outputs 0, FSM in IDLE.
- **Timeout (`MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):** never ack. Expect `stall` to release after 4 WAIT cycles, `mem_err`=1 and staying set, `RegWrite_out`=0.
